// File: rtl/fig89_run_arbiter.sv
// fig89_run_arbiter: round-robin owner of a shared Fig 8.9 counter/flag datapath
//
// Issues a one-cycle Start to the datapath on behalf of the granted requester,
// waits for F to drop (Start accepted) and rise again (run complete), then
// returns the captured A/E with a one-cycle done pulse. A run that does not
// complete within TIMEOUT cycles of entering CLEAR is aborted with res_err_o.
//
// Parameters:
//   N_REQ    number of requesters (2..8)
//   TIMEOUT  cycles from entering CLEAR until a run is aborted (1..255)
//
// Ports:
//   clock_i      system clock, rising edge
//   reset_i      asynchronous active-high reset
//   req_i        level requests, bit i held until done_o[i]
//   grant_o      one-hot owner of the datapath, zero when idle
//   done_o       one-cycle completion pulse to the owner
//   res_A_o      datapath A captured at completion
//   res_E_o      datapath E captured at completion
//   res_err_o    high with done_o when the run timed out
//   busy_o       high whenever the arbiter is not idle
//   dp_start_o   datapath Start input
//   dp_A_i       datapath A
//   dp_E_i       datapath E
//   dp_F_i       datapath F
//   run_count_o  completed good runs, saturating (FIG89_RUN_STATS_EN only)
//   err_count_o  timed-out runs, saturating (FIG89_RUN_STATS_EN only)
//
// Optional feature macro: FIG89_RUN_STATS_EN adds the run/error counters.
module fig89_run_arbiter #(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 31
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic [N_REQ-1:0] req_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [N_REQ-1:0] done_o,
   output logic [3:0]       res_A_o,
   output logic             res_E_o,
   output logic             res_err_o,
   output logic             busy_o,
   output logic             dp_start_o,
`ifdef FIG89_RUN_STATS_EN
   output logic [7:0]       run_count_o,
   output logic [3:0]       err_count_o,
`endif
   input  logic [3:0]       dp_A_i,
   input  logic             dp_E_i,
   input  logic             dp_F_i
);
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   typedef enum logic [2:0] {IDLE, ISSUE, CLEAR, RUN, DONE} state_t;
   state_t           state_q;
   logic [N_REQ-1:0] grant_q, done_q;
   logic [3:0]       res_A_q;
   logic             res_E_q, res_err_q, busy_q, dp_start_q;
   logic [IW-1:0]    rr_ptr_q, owner_q, sel_idx;
   logic             sel_vld;
   logic [7:0]       timer_q, timer_d;
   logic             timed_out;
`ifdef FIG89_RUN_STATS_EN
   logic [7:0]       run_cnt_q;
   logic [3:0]       err_cnt_q;
   assign run_count_o = run_cnt_q;
   assign err_count_o = err_cnt_q;
`endif
   assign grant_o    = grant_q;
   assign done_o     = done_q;
   assign res_A_o    = res_A_q;
   assign res_E_o    = res_E_q;
   assign res_err_o  = res_err_q;
   assign busy_o     = busy_q;
   assign dp_start_o = dp_start_q;
   // Search upward from rr_ptr+1; iterating from the far end lets the
   // nearest set bit overwrite any farther candidate.
   always_comb begin
      sel_vld = 1'b0;
      sel_idx = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         if (req_i[(int'(rr_ptr_q) + k) % N_REQ]) begin
            sel_vld = 1'b1;
            sel_idx = IW'((int'(rr_ptr_q) + k) % N_REQ);
         end
      end
   end
   // Comparing the incremented value makes done land exactly TIMEOUT
   // cycles after entering CLEAR.
   assign timer_d   = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
   assign timed_out = (timer_d == 8'(TIMEOUT));
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         done_q     <= '0;
         res_A_q    <= '0;
         res_E_q    <= 1'b0;
         res_err_q  <= 1'b0;
         busy_q     <= 1'b0;
         dp_start_q <= 1'b0;
         rr_ptr_q   <= IW'(N_REQ - 1);
         owner_q    <= '0;
         timer_q    <= '0;
`ifdef FIG89_RUN_STATS_EN
         run_cnt_q  <= '0;
         err_cnt_q  <= '0;
`endif
      end else begin
         done_q     <= '0;
         dp_start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (sel_vld) begin
                  grant_q    <= N_REQ'(1) << sel_idx;
                  owner_q    <= sel_idx;
                  dp_start_q <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= ISSUE;
               end
            end
            ISSUE: begin
               timer_q <= '0;
               state_q <= CLEAR;
            end
            CLEAR, RUN: begin
               if (state_q == RUN && dp_F_i) begin
                  res_A_q   <= dp_A_i;
                  res_E_q   <= dp_E_i;
                  res_err_q <= 1'b0;
                  done_q    <= grant_q;
                  state_q   <= DONE;
`ifdef FIG89_RUN_STATS_EN
                  run_cnt_q <= (run_cnt_q == 8'hFF) ? run_cnt_q : run_cnt_q + 8'd1;
`endif
               end else if (timed_out) begin
                  res_err_q <= 1'b1;
                  done_q    <= grant_q;
                  state_q   <= DONE;
`ifdef FIG89_RUN_STATS_EN
                  err_cnt_q <= (err_cnt_q == 4'hF) ? err_cnt_q : err_cnt_q + 4'd1;
`endif
               end else begin
                  timer_q <= timer_d;
                  state_q <= (state_q == CLEAR && !dp_F_i) ? RUN : state_q;
               end
            end
            DONE: begin
               grant_q  <= '0;
               busy_q   <= 1'b0;
               rr_ptr_q <= owner_q;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
